// File: rtl/nexys4ddr_periph_shell.sv
// rtl/nexys4ddr_periph_shell.sv - Nexys4-DDR board peripheral shell: UART console, LEDs, DIP/buttons, boot strap.
// Optional NEXYS4_UART_RX_FIFO_EN replaces the single RX holding register with an RX_FIFO_DEPTH byte FIFO.
module nexys4ddr_periph_shell #(
  parameter int BAUD_DIV_RESET = 52,
  parameter int RX_FIFO_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [4:0]  bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_rvalid_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [7:0]  led_o,
  input  logic [15:0] dip_i,
  input  logic [4:0]  btn_i,
  output logic        boot_mode_o,
  output logic        irq_o
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [19:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [15:0] tx_div_q, tx_div_d, rx_div_q, rx_div_d;
  logic [1:0]  rx_sync_q, vld_q;
  logic [15:0] dip_m_q, dip_s_q, baud_q;
  logic [4:0]  btn_m_q, btn_s_q;
  logic [7:0]  led_q, rx_head;
  logic [31:0] rdata_d;
  logic        boot_q, boot_done_q, ovr_q, ferr_q, rvalid_q;
  logic [31:0] rdata_q;
  logic        rx_s, wr, rd, tx_start, pop, st_clr, rx_valid, push, ovr_set;
  logic        rx_done, ferr_set, tx_busy;
  logic [2:0]  idx;
  logic [15:0] baud_eff;
  logic        unused_bits;

  assign rx_s     = rx_sync_q[1];
  assign idx      = bus_addr_i[4:2];
  assign wr       = bus_req_i & bus_we_i;
  assign rd       = bus_req_i & ~bus_we_i;
  assign baud_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign tx_start = wr && (idx == 3'd0) && (tx_state_q == TX_IDLE);
  assign pop      = rd && (idx == 3'd0) && rx_valid;
  assign st_clr   = rd && (idx == 3'd1);
  assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i[31:16], RX_FIFO_DEPTH};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;  rx_state_q <= RX_IDLE;
      tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_sh_q <= '0;  tx_div_q <= 16'd1;
      rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_sh_q <= '0;  rx_div_q <= 16'd1;
    end else begin
      tx_state_q <= tx_state_d;  rx_state_q <= rx_state_d;
      tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;  tx_sh_q <= tx_sh_d;  tx_div_q <= tx_div_d;
      rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;  rx_div_q <= rx_div_d;
    end
  end

  // TX counts down one full bit period (div*16 clocks) per state step.
  always_comb begin
    tx_state_d = tx_state_q;  tx_cnt_d = tx_cnt_q;  tx_bit_d = tx_bit_q;
    tx_sh_d    = tx_sh_q;     tx_div_d = tx_div_q;
    case (tx_state_q)
      TX_IDLE: if (tx_start) begin
        tx_state_d = TX_START;  tx_sh_d = bus_wdata_i[7:0];  tx_div_d = baud_eff;
        tx_cnt_d   = {baud_eff, 4'b0000} - 20'd1;  tx_bit_d = '0;
      end
      TX_START: if (tx_cnt_q == '0) begin
        tx_state_d = TX_DATA;  tx_cnt_d = {tx_div_q, 4'b0000} - 20'd1;
      end else tx_cnt_d = tx_cnt_q - 20'd1;
      TX_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = {tx_div_q, 4'b0000} - 20'd1;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        else tx_bit_d = tx_bit_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q - 20'd1;
      default: if (tx_cnt_q == '0) tx_state_d = TX_IDLE;
               else tx_cnt_d = tx_cnt_q - 20'd1;
    endcase
  end

  always_comb begin
    tx_busy   = (tx_state_q != TX_IDLE);
    uart_tx_o = 1'b1;
    if (tx_state_q == TX_START)     uart_tx_o = 1'b0;
    else if (tx_state_q == TX_DATA) uart_tx_o = tx_sh_q[0];
  end

  // RX counts up; the first wait is half a bit so every later sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;  rx_cnt_d = rx_cnt_q + 20'd1;  rx_bit_d = rx_bit_q;
    rx_sh_d    = rx_sh_q;     rx_div_d = rx_div_q;
    rx_done    = 1'b0;        ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) begin rx_state_d = RX_START;  rx_div_d = baud_eff; end
      end
      RX_START: if (rx_cnt_q == {1'b0, rx_div_q, 3'b000} - 20'd1) begin
        rx_cnt_d = '0;  rx_bit_d = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == {rx_div_q, 4'b0000} - 20'd1) begin
        rx_cnt_d = '0;  rx_sh_d = {rx_s, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_cnt_q == {rx_div_q, 4'b0000} - 20'd1) begin
        rx_cnt_d = '0;
        if (rx_s) begin rx_state_d = RX_IDLE;  rx_done = 1'b1; end
        else begin rx_state_d = RX_WAIT;  ferr_set = 1'b1; end
      end
      default: begin
        rx_cnt_d = '0;
        if (rx_s) rx_state_d = RX_IDLE;
      end
    endcase
  end

`ifdef NEXYS4_UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0]  fifo_q [RX_FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic        full;
  assign rx_valid = (wp_q != rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rx_head  = fifo_q[rp_q[AW-1:0]];
  assign push     = rx_done && (!full || pop);
  assign ovr_set  = rx_done && full && !pop;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;  rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) if (push) fifo_q[wp_q[AW-1:0]] <= rx_sh_q;
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;
  assign rx_valid = hold_vld_q;
  assign rx_head  = hold_q;
  assign push     = rx_done && (!hold_vld_q || pop);
  assign ovr_set  = rx_done && hold_vld_q && !pop;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;  hold_vld_q <= 1'b0;
    end else if (push) begin
      hold_q <= rx_sh_q;  hold_vld_q <= 1'b1;
    end else if (pop) hold_vld_q <= 1'b0;
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (idx)
        3'd0: rdata_d = rx_valid ? {24'b0, rx_head} : 32'b0;
        3'd1: rdata_d = {28'b0, ferr_q, ovr_q, tx_busy, rx_valid};
        3'd2: rdata_d = {16'b0, baud_q};
        3'd3: rdata_d = {24'b0, led_q};
        3'd4: rdata_d = {16'b0, dip_s_q};
        3'd5: rdata_d = {27'b0, btn_s_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q <= 2'b11;  dip_m_q <= '0;  dip_s_q <= '0;  btn_m_q <= '0;  btn_s_q <= '0;
      vld_q <= '0;  boot_q <= 1'b1;  boot_done_q <= 1'b0;
      baud_q <= 16'(BAUD_DIV_RESET);  led_q <= '0;  ovr_q <= 1'b0;  ferr_q <= 1'b0;
      rvalid_q <= 1'b0;  rdata_q <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx_i};
      dip_m_q <= dip_i;  dip_s_q <= dip_m_q;  btn_m_q <= btn_i;  btn_s_q <= btn_m_q;
      vld_q <= {vld_q[0], 1'b1};
      if (vld_q[1] && !boot_done_q) begin
        boot_q <= dip_s_q[0];  boot_done_q <= 1'b1;
      end
      if (wr && idx == 3'd2) baud_q <= (bus_wdata_i[15:0] == 16'd0) ? 16'd1 : bus_wdata_i[15:0];
      if (wr && idx == 3'd3) led_q <= bus_wdata_i[7:0];
      ovr_q    <= (ovr_q & ~st_clr) | ovr_set;
      ferr_q   <= (ferr_q & ~st_clr) | ferr_set;
      rvalid_q <= rd;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_rdata_o  = rdata_q;
  assign bus_rvalid_o = rvalid_q;
  assign led_o        = led_q;
  assign boot_mode_o  = boot_q;
  assign irq_o        = rx_valid;
endmodule

// File: tb/tb_nexys4ddr_periph_shell.sv
// tb/tb_nexys4ddr_periph_shell.sv - Directed self-checking bench for nexys4ddr_periph_shell (default build).
module tb_nexys4ddr_periph_shell;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [4:0]  addr;
  logic [31:0] wdata, rdata;
  logic        rvalid, uart_rx, uart_tx, boot_mode, irq;
  logic [7:0]  led;
  logic [15:0] dip;
  logic [4:0]  btn;
  logic        loop_en, rx_drv;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  assign uart_rx = loop_en ? uart_tx : rx_drv;

  nexys4ddr_periph_shell dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_req_i(req), .bus_we_i(we), .bus_addr_i(addr),
    .bus_wdata_i(wdata), .bus_rdata_o(rdata), .bus_rvalid_o(rvalid), .uart_rx_i(uart_rx),
    .uart_tx_o(uart_tx), .led_o(led), .dip_i(dip), .btn_i(btn), .boot_mode_o(boot_mode),
    .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    req = 1'b1;  we = 1'b1;  addr = a;  wdata = d;
    @(negedge clk);
    req = 1'b0;  we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    req = 1'b1;  we = 1'b0;  addr = a;
    @(negedge clk);
    req = 1'b0;
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    d = rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  // 16 clocks per bit matches BAUD_DIV=1.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  tx_exp;
    logic [31:0] d;
    int          budget;
    rst_n = 1'b0;  req = 1'b0;  we = 1'b0;  addr = '0;  wdata = '0;
    dip = 16'h0000;  btn = 5'h00;  loop_en = 1'b0;  rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_led", {24'b0, led}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_boot", {31'b0, boot_mode}, 32'd1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("boot_strap0", {31'b0, boot_mode}, 32'd0);
    rd_chk("baud_reset", 5'h08, 32'd52);
    rd_chk("status_reset", 5'h04, 32'd0);

    bus_write(5'h0C, 32'hFFFF_FFA5);
    chk("led_pin", {24'b0, led}, 32'hA5);
    rd_chk("led_read", 5'h0C, 32'hA5);
    dip = 16'h0001;  btn = 5'h15;
    repeat (2) @(negedge clk);
    rd_chk("dip_read", 5'h10, 32'h1);
    rd_chk("btn_read", 5'h14, 32'h15);
    chk("boot_hold", {31'b0, boot_mode}, 32'd0);
    rd_chk("unmapped", 5'h1C, 32'd0);

    // Frame at reset divisor: 832 clocks per bit, sampled mid-bit.
    tx_exp = {1'b1, 8'h41, 1'b0};
    bus_write(5'h00, 32'h41);
    repeat (416) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d", i), {31'b0, uart_tx}, {31'b0, tx_exp[i]});
      if (i == 1) bus_write(5'h00, 32'h00);
      else begin
        bus_read(5'h04, d);
        chk($sformatf("tx_busy%0d", i), {31'b0, d[1]}, 32'd1);
      end
      repeat (831) @(negedge clk);
    end
    chk("tx_idle_line", {31'b0, uart_tx}, 32'd1);
    rd_chk("tx_idle_status", 5'h04, 32'd0);

    bus_write(5'h00, 32'h00);
    repeat (100) @(negedge clk);
    chk("midframe_low", {31'b0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("async_rst_led", {24'b0, led}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("boot_strap1", {31'b0, boot_mode}, 32'd1);
    rd_chk("baud_after_rst", 5'h08, 32'd52);
    rd_chk("status_after_rst", 5'h04, 32'd0);

    bus_write(5'h08, 32'd1);
    loop_en = 1'b1;
    bus_write(5'h00, 32'h5A);
    budget = 0;
    while (!irq && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk("loop_irq_rise", {31'b0, irq}, 32'd1);
    repeat (20) @(negedge clk);
    loop_en = 1'b0;
    rd_chk("loop_data", 5'h00, 32'h5A);
    chk("loop_irq_fall", {31'b0, irq}, 32'd0);

    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    rd_chk("glitch_reject", 5'h04, 32'd0);

    send_rx(8'h33, 1'b0);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk("err_status", 5'h04, 32'hD);
    rd_chk("err_cleared", 5'h04, 32'h1);
    rd_chk("first_byte_kept", 5'h00, 32'h11);
    rd_chk("status_empty", 5'h04, 32'h0);
    rd_chk("empty_read", 5'h00, 32'h0);
    chk("irq_empty", {31'b0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nexys4ddr_periph_shell.md
# nexys4ddr_periph_shell

Board-facing peripheral shell for the Nexys4-DDR Ariane SoC. Sits between the core's simple register bus and the board pins, providing an 8N1 UART console, an LED output register, synchronized DIP-switch and push-button inputs, a boot-mode strap and a UART receive interrupt. Everything runs on the single system clock.

## Interface
Parameters:
- BAUD_DIV_RESET, 52: reset value of the baud divisor. Bit period is BAUD_DIV×16 clocks.
- RX_FIFO_DEPTH, 16: receive FIFO depth. Power of two. Used only with the FIFO macro.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- bus_req_i  in  1  register access strobe; one access per cycle.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_i  in  5  byte address; bits [1:0] are ignored.
- bus_wdata_i  in  32  write data.
- bus_rdata_o  out  32  read data, qualified by bus_rvalid_o.
- bus_rvalid_o  out  1  pulses 1 cycle after each read request.
- uart_rx_i  in  1  serial input; asynchronous; idle high.
- uart_tx_o  out  1  serial output; idle high.
- led_o  out  8  LED drive.
- dip_i  in  16  DIP switches; asynchronous.
- btn_i  in  5  push buttons {C,W,E,N,S}; asynchronous.
- boot_mode_o  out  1  latched boot strap.
- irq_o  out  1  high while RX data is available.

## Operation
Register map (word aligned):
- 0x00 UART_DATA.
  - Write: if TX is idle, load wdata[7:0] and start a frame. If TX is busy, the write is silently dropped.
  - Read: returns {24'b0, byte} and pops one RX byte. If RX is empty, returns 0 with no side effect.
- 0x04 STATUS (read-only):
  - bit0 rx_valid.
  - bit1 tx_busy.
  - bit2 rx_overrun: sticky; cleared by reading STATUS.
  - bit3 frame_err: sticky; cleared by reading STATUS.
- 0x08 BAUD_DIV [15:0]: read/write, reset BAUD_DIV_RESET. A written value of 0 is treated as 1.
- 0x0C LED [7:0]: read/write, reset 0, drives led_o directly.
- 0x10 DIP [15:0]: read-only, 2-flop synchronized dip_i.
- 0x14 BTN [4:0]: read-only, 2-flop synchronized btn_i.
- Other addresses: read 0, writes ignored.

UART TX:
- Frame: start bit 0, 8 data bits LSB first, stop bit 1.
- States IDLE→START→DATA(8)→STOP→IDLE; tx_busy is high in every state except IDLE.
- BAUD_DIV is latched at frame start; a mid-frame change applies to the next frame.

UART RX:
- uart_rx_i is 2-flop synchronized.
- Falling edge in IDLE → START. At the mid-bit tick (8 subticks) the line is rechecked; if high, return to IDLE (glitch rejected).
- DATA: 8 samples at mid-bit, LSB first. STOP: one mid-bit sample.
- Stop bit = 0: set frame_err, discard the byte, and go to IDLE only after the line returns high.
- Byte accepted while storage is full: discard the new byte, set rx_overrun.

Other outputs:
- irq_o = rx_valid.
- boot_mode_o captures synchronized dip[0] on the first cycle the synchronizer output is valid after reset release, then holds until the next reset. 1 = normal boot, 0 = boot from debug RAM.

## Timing
- Write effects are visible in registers and pins on the cycle after the bus_req_i edge.
- TX start bit begins the cycle after an accepted UART_DATA write.
- Read data appears with bus_rvalid_o exactly 1 cycle after the request. Pop and sticky-clear side effects occur on that same edge.
- Simultaneous RX byte completion and a UART_DATA read that pops the last byte: the pop occurs first and the new byte is stored, with no overrun.
- Reset values (async reset may assert mid-frame; all state clears immediately):
  - uart_tx_o=1, led_o=0, irq_o=0, bus_rvalid_o=0, bus_rdata_o=0, boot_mode_o=1.
  - Both UART FSMs in IDLE; FIFO/holding register empty; sticky flags 0.
- Input synchronizer latency: 2 cycles.

## Configuration
- NEXYS4_UART_RX_FIFO_EN defined: RX storage is a FIFO of RX_FIFO_DEPTH bytes; rx_valid = not empty; overrun occurs only when the FIFO is full.
- Undefined: RX storage is a single holding register; a second byte arriving before it is read sets rx_overrun and is discarded.

## Test plan
- Reset: hold rst_ni=0 mid-TX frame → uart_tx_o=1, led_o=0, BAUD_DIV reads 52, STATUS reads 0.
- TX: write 0x41 to 0x00 → line shows start 0, bits 1,0,0,0,0,0,1,0, stop 1, each 832 clocks; tx_busy=1 throughout; a second write during the frame is dropped.
- Loopback: tie uart_tx_o to uart_rx_i, send 0x5A → irq_o rises; read 0x00 returns 0x5A; irq_o falls.
- Errors: inject a stop bit of 0 → frame_err=1 and no data; send 2 bytes without reading (macro off) → first byte kept, rx_overrun=1; a STATUS read clears both flags.
- Registers: write LED=0xA5 → led_o=0xA5 next cycle; set dip_i=0x0001, btn_i=0x15 → DIP reads 1 and BTN reads 0x15 after 2 cycles; unmapped 0x1C reads 0.
- Boot strap: dip_i[0]=0 at reset release → boot_mode_o=0, and it stays 0 after dip_i[0] later goes to 1.
